// File: rtl/reorder_buffer_reservation_arbiter_pkg.sv
// Shared types and the rotate-and-priority-encode helper for the reservation arbiter.
package reorder_buffer_arbiter_pkg;

    localparam int MAX_REQUESTERS = 32;
    localparam int SCAN_BITS = $clog2(MAX_REQUESTERS);
    localparam int DEFAULT_OWNER_WIDTH = 2;

    typedef logic [DEFAULT_OWNER_WIDTH-1:0] owner_t;

    // Returns the first set bit of eligible scanning pointer, pointer+1, ... modulo
    // requesters, or -1 when nothing is eligible.
    function automatic int rotate_priority_winner(
        input logic [MAX_REQUESTERS-1:0] eligible,
        input int pointer,
        input int requesters
    );
        int winner;
        int idx;
        winner = -1;
        for (int k = 0; k < MAX_REQUESTERS; k++) begin
            if (k < requesters) begin
                idx = pointer + k;
                if (idx >= requesters) idx = idx - requesters;
                if (winner < 0 && eligible[idx[SCAN_BITS-1:0]]) winner = idx;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/reorder_buffer_reservation_arbiter_round_robin_arbiter.sv
// Zero-latency round-robin arbiter; the priority pointer moves past each winner.
module round_robin_arbiter
    import reorder_buffer_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int OWNER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [REQUESTERS-1:0]  request,
    output logic [REQUESTERS-1:0]  grant,
    output logic [OWNER_WIDTH-1:0] winner
);

    logic [OWNER_WIDTH-1:0] pointer;
    int winner_int;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        grant = '0;
        winner = '0;
        winner_int = rotate_priority_winner(MAX_REQUESTERS'(request), int'(pointer), REQUESTERS);
        if (winner_int >= 0) begin
            winner = OWNER_WIDTH'(winner_int);
            grant[winner] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pointer <= '0;
        end else if (|grant) begin
            pointer <= (winner == OWNER_WIDTH'(REQUESTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer_reservation_arbiter.sv
// Shares one reorder buffer reservation port among requesters and routes each
// in-order read back to the requester that reserved the entry.
module reorder_buffer_reservation_arbiter
    import reorder_buffer_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int DEPTH = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int OWNER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1,
    parameter int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [REQUESTERS-1:0]  request_valid,
    output logic [REQUESTERS-1:0]  request_ready,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic [OWNER_WIDTH-1:0] grant_owner,
    output logic                   rob_reserve_enable,
    input  logic [INDEX_WIDTH-1:0] rob_reserve_index,
    input  logic                   rob_read_enable,
    output logic [OWNER_WIDTH-1:0] read_owner,
    output logic [REQUESTERS-1:0]  outstanding_full,
    output logic                   occupancy_full,
    output logic                   occupancy_empty,
    output logic                   read_error
);

    localparam int OCCUPANCY_WIDTH = $clog2(DEPTH + 1);

    logic [COUNT_WIDTH-1:0]     outstanding [REQUESTERS];
    logic [OWNER_WIDTH-1:0]     owner_table [DEPTH];
    logic [INDEX_WIDTH-1:0]     read_pointer;
    logic [OCCUPANCY_WIDTH-1:0] occupancy;
    logic [REQUESTERS-1:0]      eligible;
    logic [REQUESTERS-1:0]      grant;
    logic [REQUESTERS-1:0]      count_down;
    logic [OWNER_WIDTH-1:0]     winner;
    logic                       granting;
    logic                       reading;

    assign occupancy_full  = (occupancy == OCCUPANCY_WIDTH'(DEPTH));
    assign occupancy_empty = (occupancy == '0);

    always_comb begin
        outstanding_full = '0;
        count_down = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            outstanding_full[i] = (outstanding[i] == COUNT_WIDTH'(MAX_OUTSTANDING));
            count_down[i] = reading && (read_owner == OWNER_WIDTH'(i));
        end
    end

    // Eligibility uses registered state only, so a read never frees a slot for a same-cycle grant.
    assign eligible = request_valid & ~outstanding_full & {REQUESTERS{!occupancy_full && resetn}};

    round_robin_arbiter #(
        .REQUESTERS  (REQUESTERS),
        .OWNER_WIDTH (OWNER_WIDTH)
    ) u_arbiter (
        .clock   (clock),
        .resetn  (resetn),
        .request (eligible),
        .grant   (grant),
        .winner  (winner)
    );

    assign granting           = |grant;
    assign request_ready      = grant;
    assign rob_reserve_enable = granting;
    assign grant_index        = rob_reserve_index;
    assign grant_owner        = winner;

    assign read_owner = owner_table[read_pointer];
    assign reading    = rob_read_enable && !occupancy_empty;
    assign read_error = rob_read_enable && occupancy_empty && resetn;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the owner table is reset deliberately; a reset must discard all ownership.
            for (int i = 0; i < DEPTH; i++) owner_table[i] <= '0;
            read_pointer <= '0;
            occupancy <= '0;
        end else begin
            if (granting) owner_table[rob_reserve_index] <= winner;
            if (reading) begin
                read_pointer <= (read_pointer == INDEX_WIDTH'(DEPTH - 1)) ? '0 : read_pointer + 1'b1;
            end
            if (granting && !reading) occupancy <= occupancy + 1'b1;
            else if (reading && !granting) occupancy <= occupancy - 1'b1;
        end
    end

    // A grant and a read for the same requester cancel, leaving its counter unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REQUESTERS; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (grant[i] && !count_down[i]) outstanding[i] <= outstanding[i] + 1'b1;
                else if (count_down[i] && !grant[i]) outstanding[i] <= outstanding[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_reservation_arbiter.sv
// Scoreboard bench: tests queue expected grants; a monitor pops them and checks read routing.
module tb_reorder_buffer_reservation_arbiter;
    import reorder_buffer_arbiter_pkg::*;

    typedef struct packed {
        owner_t     owner;
        logic [2:0] slot;
    } grant_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] request_valid;
    logic [3:0] request_ready;
    logic [2:0] grant_index;
    logic [1:0] grant_owner;
    logic       rob_reserve_enable;
    logic [2:0] rob_reserve_index;
    logic       rob_read_enable;
    logic [1:0] read_owner;
    logic [3:0] outstanding_full;
    logic       occupancy_full;
    logic       occupancy_empty;
    logic       read_error;

    grant_t exp_grant_q[$];
    owner_t owner_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic [2:0] rob_tail;

    reorder_buffer_reservation_arbiter dut (
        .clock              (clock),
        .resetn             (resetn),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .grant_index        (grant_index),
        .grant_owner        (grant_owner),
        .rob_reserve_enable (rob_reserve_enable),
        .rob_reserve_index  (rob_reserve_index),
        .rob_read_enable    (rob_read_enable),
        .read_owner         (read_owner),
        .outstanding_full   (outstanding_full),
        .occupancy_full     (occupancy_full),
        .occupancy_empty    (occupancy_empty),
        .read_error         (read_error)
    );

    always #5 clock = ~clock;

    function automatic grant_t make_grant(input int owner, input int slot);
        grant_t g;
        g.owner = owner_t'(owner);
        g.slot = 3'(slot);
        return g;
    endfunction

    // Advance one clock; the bench plays the reorder buffer tail pointer.
    task automatic tick();
        logic reserved;
        #1;
        reserved = rob_reserve_enable;
        @(posedge clock);
        #1;
        if (reserved && resetn) rob_tail = rob_tail + 1'b1;
        rob_reserve_index = rob_tail;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        request_valid = '0;
        rob_read_enable = 1'b0;
        exp_grant_q.delete();
        owner_q.delete();
        rob_tail = '0;
        rob_reserve_index = '0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    // Monitor: samples mid-cycle, compares flags against the owner model, pops the scoreboards.
    int mon_counts[4];
    logic [3:0] mon_full;
    owner_t mon_owner;
    grant_t mon_grant;
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (resetn) begin
                for (int i = 0; i < 4; i++) mon_counts[i] = 0;
                foreach (owner_q[j]) mon_counts[owner_q[j]]++;
                for (int i = 0; i < 4; i++) mon_full[i] = (mon_counts[i] == 4);
                vectors++;
                if (occupancy_empty !== (owner_q.size() == 0) || occupancy_full !== (owner_q.size() == 8)) begin
                    miscompares++;
                    $display("FAIL occupancy_flags: got empty=%b full=%b want entries=%0d", occupancy_empty, occupancy_full, owner_q.size());
                end
                vectors++;
                if (outstanding_full !== mon_full) begin
                    miscompares++;
                    $display("FAIL outstanding_full: got %b want %b", outstanding_full, mon_full);
                end
                if (rob_read_enable && owner_q.size() == 0) begin
                    vectors++;
                    if (read_error !== 1'b1) begin
                        miscompares++;
                        $display("FAIL read_error_empty: got %b want 1", read_error);
                    end
                end else if (rob_read_enable) begin
                    mon_owner = owner_q.pop_front();
                    vectors++;
                    if (read_owner !== mon_owner || read_error !== 1'b0) begin
                        miscompares++;
                        $display("FAIL read_owner: got %0d err=%b want %0d err=0", read_owner, read_error, mon_owner);
                    end
                end else begin
                    vectors++;
                    if (read_error !== 1'b0) begin
                        miscompares++;
                        $display("FAIL read_error_idle: got %b want 0", read_error);
                    end
                end
                if (rob_reserve_enable) begin
                    vectors++;
                    if (exp_grant_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_grant: got owner %0d index %0d want none", grant_owner, grant_index);
                    end else begin
                        mon_grant = exp_grant_q.pop_front();
                        if (grant_owner !== mon_grant.owner || grant_index !== mon_grant.slot
                            || request_ready !== (4'b0001 << mon_grant.owner)) begin
                            miscompares++;
                            $display("FAIL grant: got owner %0d index %0d ready %b want owner %0d index %0d",
                                     grant_owner, grant_index, request_ready, mon_grant.owner, mon_grant.slot);
                        end
                        owner_q.push_back(mon_grant.owner);
                    end
                end else begin
                    vectors++;
                    if (request_ready !== 4'b0000 || grant_owner !== 2'd0) begin
                        miscompares++;
                        $display("FAIL idle_grant: got ready %b owner %0d want 0000 0", request_ready, grant_owner);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        request_valid = 4'hF;
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if ({request_ready, rob_reserve_enable, outstanding_full, occupancy_full, occupancy_empty, read_error}
            !== 12'b0000_0_0000_0_1_0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready %b rsv %b ofull %b full %b empty %b err %b",
                     request_ready, rob_reserve_enable, outstanding_full, occupancy_full, occupancy_empty, read_error);
        end
        do_reset();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 6; k++) exp_grant_q.push_back(make_grant(k % 4, k));
        request_valid = 4'hF;
        tick();
        rob_read_enable = 1'b1;
        repeat (5) tick();
        request_valid = '0;
        tick();
        rob_read_enable = 1'b0;
        #1;
        vectors++;
        if (exp_grant_q.size() != 0 || occupancy_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fairness_drain: got pending %0d empty %b want 0 1", exp_grant_q.size(), occupancy_empty);
        end
    endtask

    task automatic test_limit();
        do_reset();
        for (int k = 0; k < 4; k++) exp_grant_q.push_back(make_grant(2, k));
        request_valid = 4'b0100;
        repeat (4) tick();
        #1;
        vectors++;
        if (outstanding_full !== 4'b0100 || request_ready !== 4'b0000 || exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL limit_full: got ofull %b ready %b pending %0d want 0100 0000 0",
                     outstanding_full, request_ready, exp_grant_q.size());
        end
        tick();
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if (request_ready !== 4'b0000 || read_owner !== 2'd2) begin
            miscompares++;
            $display("FAIL limit_read: got ready %b owner %0d want 0000 2", request_ready, read_owner);
        end
        tick();
        rob_read_enable = 1'b0;
        exp_grant_q.push_back(make_grant(2, 4));
        tick();
        request_valid = '0;
        #1;
        vectors++;
        if (exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL limit_regrant: got pending %0d want 0", exp_grant_q.size());
        end
    endtask

    task automatic test_occupancy_full();
        do_reset();
        for (int k = 0; k < 8; k++) exp_grant_q.push_back(make_grant(k % 2, k));
        request_valid = 4'b0011;
        repeat (8) tick();
        #1;
        vectors++;
        if (occupancy_full !== 1'b1 || request_ready !== 4'b0000 || exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL occ_full: got full %b ready %b pending %0d want 1 0000 0",
                     occupancy_full, request_ready, exp_grant_q.size());
        end
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if (request_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL occ_read_no_grant: got ready %b want 0000", request_ready);
        end
        tick();
        rob_read_enable = 1'b0;
        exp_grant_q.push_back(make_grant(0, 0));
        tick();
        request_valid = '0;
        #1;
        vectors++;
        if (exp_grant_q.size() != 0 || occupancy_full !== 1'b1) begin
            miscompares++;
            $display("FAIL occ_refill: got pending %0d full %b want 0 1", exp_grant_q.size(), occupancy_full);
        end
    endtask

    task automatic test_ownership();
        logic [3:0] seq [4];
        seq = '{4'b1000, 4'b0001, 4'b1000, 4'b0010};
        do_reset();
        exp_grant_q.push_back(make_grant(3, 0));
        exp_grant_q.push_back(make_grant(0, 1));
        exp_grant_q.push_back(make_grant(3, 2));
        exp_grant_q.push_back(make_grant(1, 3));
        for (int k = 0; k < 4; k++) begin
            request_valid = seq[k];
            tick();
        end
        request_valid = '0;
        rob_read_enable = 1'b1;
        repeat (4) tick();
        rob_read_enable = 1'b0;
        #1;
        vectors++;
        if (occupancy_empty !== 1'b1 || outstanding_full !== 4'b0000 || exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL ownership_drain: got empty %b ofull %b pending %0d want 1 0000 0",
                     occupancy_empty, outstanding_full, exp_grant_q.size());
        end
    endtask

    task automatic test_same_owner();
        do_reset();
        exp_grant_q.push_back(make_grant(1, 0));
        exp_grant_q.push_back(make_grant(1, 1));
        request_valid = 4'b0010;
        repeat (2) tick();
        exp_grant_q.push_back(make_grant(1, 2));
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if (request_ready !== 4'b0010 || read_owner !== 2'd1) begin
            miscompares++;
            $display("FAIL same_owner_overlap: got ready %b owner %0d want 0010 1", request_ready, read_owner);
        end
        tick();
        rob_read_enable = 1'b0;
        exp_grant_q.push_back(make_grant(1, 3));
        exp_grant_q.push_back(make_grant(1, 4));
        repeat (2) tick();
        #1;
        vectors++;
        if (outstanding_full !== 4'b0010 || request_ready !== 4'b0000 || exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL same_owner_count: got ofull %b ready %b pending %0d want 0010 0000 0",
                     outstanding_full, request_ready, exp_grant_q.size());
        end
        request_valid = '0;
    endtask

    task automatic test_read_error();
        do_reset();
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if (read_error !== 1'b1) begin
            miscompares++;
            $display("FAIL read_error: got %b want 1", read_error);
        end
        tick();
        rob_read_enable = 1'b0;
        exp_grant_q.push_back(make_grant(2, 0));
        request_valid = 4'b0100;
        tick();
        request_valid = '0;
        rob_read_enable = 1'b1;
        #1;
        vectors++;
        if (read_owner !== 2'd2 || read_error !== 1'b0) begin
            miscompares++;
            $display("FAIL read_after_error: got owner %0d err %b want 2 0", read_owner, read_error);
        end
        tick();
        rob_read_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) exp_grant_q.push_back(make_grant(k % 4, k));
        request_valid = 4'hF;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        vectors++;
        if (occupancy_empty !== 1'b1 || outstanding_full !== 4'b0000 || request_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid: got empty %b ofull %b ready %b want 1 0000 0000",
                     occupancy_empty, outstanding_full, request_ready);
        end
        do_reset();
        exp_grant_q.push_back(make_grant(0, 0));
        request_valid = 4'hF;
        tick();
        request_valid = '0;
        #1;
        vectors++;
        if (exp_grant_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_first_grant: got pending %0d want 0", exp_grant_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        request_valid = '0;
        rob_read_enable = 1'b0;
        rob_tail = '0;
        rob_reserve_index = '0;
        test_reset();
        test_fairness();
        test_limit();
        test_occupancy_full();
        test_ownership();
        test_same_owner();
        test_read_error();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_reservation_arbiter.md
Name: reorder_buffer_reservation_arbiter

Overview:
Shares the reservation port of one reorder buffer controller between REQUESTERS independent issuers using round-robin arbitration. It enforces a per-requester outstanding-entry limit and tracks total occupancy. It records the owning requester of every reserved entry, so that each in-order read can be routed back to its originator. It sits between the issuers and the reorder buffer controller's reserve and read interfaces.

Parameters:
REQUESTERS, 4, number of requesters sharing the reservation port
DEPTH, 8, reorder buffer depth; must match the controlled buffer
MAX_OUTSTANDING, 4, maximum entries one requester may hold (reserved and not yet read), 1..DEPTH
INDEX_WIDTH, $clog2(DEPTH), reorder buffer index width
OWNER_WIDTH, $clog2(REQUESTERS) (minimum 1), requester identifier width
COUNT_WIDTH, $clog2(MAX_OUTSTANDING+1), per-requester counter width

Ports:
clock  input  1  clock
resetn  input  1  asynchronous active-low reset
request_valid  input  REQUESTERS  per-requester reservation request
request_ready  output  REQUESTERS  one-hot grant; transfer when valid&ready
grant_index  output  INDEX_WIDTH  reorder index returned to the granted requester
grant_owner  output  OWNER_WIDTH  identifier of the granted requester
rob_reserve_enable  output  1  to reorder buffer reserve_enable
rob_reserve_index  input  INDEX_WIDTH  from reorder buffer reserve_index
rob_read_enable  input  1  in-order read of the reorder buffer head this cycle
read_owner  output  OWNER_WIDTH  owner of the entry being read (valid with rob_read_enable)
outstanding_full  output  REQUESTERS  per requester: counter == MAX_OUTSTANDING
occupancy_full  output  1  total reserved entries == DEPTH
occupancy_empty  output  1  total reserved entries == 0
read_error  output  1  rob_read_enable while occupancy is 0

Behaviour:
- Reset is decided: reset resetn, asynchronous, active-low; clock clock.
- Reset state: priority pointer 0, read pointer 0, occupancy 0, all outstanding counters 0, owner table 0.
- Outputs during reset: request_ready 0, rob_reserve_enable 0, outstanding_full 0, occupancy_full 0, occupancy_empty 1, read_error 0.
- Eligibility of requester i: request_valid[i] && !outstanding_full[i] && !occupancy_full. All three are computed from registered state, so a same-cycle read never frees a slot for a same-cycle grant.
- Arbitration is combinational, zero latency. Winner = first eligible requester scanning i = pointer, pointer+1, ... modulo REQUESTERS. request_ready is one-hot or zero.
- rob_reserve_enable = |request_ready. grant_index = rob_reserve_index. grant_owner = winner, and is 0 when there is no grant.
- On a grant, the next cycle has:
  - owner_table[rob_reserve_index] <= winner
  - outstanding[winner] incremented
  - occupancy incremented
  - pointer <= (winner+1) mod REQUESTERS
- With no grant, the pointer holds.
- On rob_read_enable with occupancy > 0:
  - read_owner = owner_table[read_pointer], combinational.
  - Next cycle: read_pointer <= read_pointer+1 (wraps DEPTH-1 -> 0), outstanding[read_owner] decremented, occupancy decremented.
- Simultaneous grant and read:
  - Occupancy unchanged.
  - If winner == read_owner, that counter is unchanged.
  - Owner-table write and read never alias: the write targets the tail and the read targets the head, and the buffer is not full when granting.
- rob_read_enable with occupancy 0: read_error = 1 combinationally, state unchanged, read_owner = owner_table[read_pointer] (don't-care).
- Requester holding valid without ready must keep it asserted. Dropping it is legal and simply withdraws the request.
- Counters never overflow or underflow by construction. Non-power-of-two DEPTH is supported by an explicit wrap compare.
- Reset mid-operation discards all ownership and counts. The reorder buffer is reset by the same resetn.

Decomposition:
- Package reorder_buffer_arbiter_pkg: owner_t, and a helper function for the rotate-and-priority-encode winner computation.
- One sub-module, round_robin_arbiter (REQUESTERS): request vector in, one-hot grant out, pointer register updated on grant.
- The top level holds the owner table, read pointer, occupancy and outstanding counters.

Test Plan:
- Fairness: REQUESTERS=4, all four valid continuously, reads every cycle after the first grant -> grants in order 0,1,2,3,0,1; grant_index 0,1,2,3,4,5.
- Per-requester limit: only requester 2 valid, no reads -> 4 grants (indices 0..3), then outstanding_full[2]=1 and request_ready=0. One read -> read_owner=2, and requester 2 is granted again the following cycle with index 4.
- Occupancy full: requesters 0 and 1 valid, no reads -> 8 grants alternating 0,1. Then occupancy_full=1 and no ready. A read in the full cycle does not allow a same-cycle grant; the grant happens the next cycle.
- Ownership routing: grants 3,0,3,1, then 4 consecutive reads -> read_owner 3,0,3,1; outstanding counters return to 0; occupancy_empty=1.
- Simultaneous grant and read by the same owner: requester 1 holds 2 entries at the head and is granted while its head entry is read -> outstanding[1] stays 2, occupancy unchanged.
- Error and reset: read on empty -> read_error=1 with no state change. Reset asserted mid-stream with 5 entries outstanding -> occupancy_empty=1, all counters 0, and the first post-reset grant goes to requester 0 with index 0.
